alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
// Integer ALU of the execute stage. Computes a two-operand arithmetic, logic,
// shift or compare result selected by a 5-bit operation code. The result and a
// zero flag are registered, so both are valid one clock after the operands.
// The operation code is {funct3, alt, 1'b0}; alt selects SUB and SRA.
//
// PARAMETERS
// WIDTH  32  operand/result width in bits; power of two, >= 8
//
// PORTS
// clk         in   1      clock; all state updates on rising edge
// rst         in   1      synchronous, active-high reset
// a           in   WIDTH  operand A (rs1)
// b           in   WIDTH  operand B (rs2/immediate); low log2(WIDTH) bits = shift amount
// alu_op      in   5      operation select (encodings below)
// alu_result  out  WIDTH  registered result
// zero        out  1      registered flag, 1 when alu_result == 0
//
// BEHAVIOUR
// - One clock, clk. Reset is synchronous and active-high (rst).
// - Reset: rst=1 at a rising edge forces alu_result=0, zero=1 (consistent with a zero result).
//   Reset overrides any operation presented in the same cycle.
// - Latency: operands/op sampled at rising edge N; alu_result/zero valid after edge N, held
//   until edge N+1. No handshake; a new operation is accepted every cycle.
// - Encodings (alu_op):
//   00000 ADD   a + b, modulo 2^WIDTH (carry discarded)
//   00010 SUB   a - b, modulo 2^WIDTH (borrow discarded)
//   00100 SLL   a << b[S-1:0], zero fill
//   01000 SLT   {0.., ($signed(a) < $signed(b))}
//   01100 SLTU  {0.., (a < b)} unsigned
//   10000 XOR   a ^ b
//   10100 SRL   a >> b[S-1:0], zero fill
//   10110 SRA   $signed(a) >>> b[S-1:0], sign fill
//   11000 OR    a | b
//   11100 AND   a & b
//   Here S = log2(WIDTH) (5 for 32). Upper bits of b ignored for shifts.
// - Any other code (including alu_op[0]=1): result 0, zero=1. No error output.
// - zero derived from the registered result value, never stale relative to alu_result.
// - No overflow/carry flags. Shift amount 0 returns a unchanged.
// - Compare results occupy bit 0; upper WIDTH-1 bits are 0.
//
// TESTING
// 1. a=2,b=1: ADD->3 z0; SUB->1 z0; AND->0 z1; OR->3 z0; XOR->3 z0 (one op per cycle, 1-cycle latency)
// 2. a=0,b=0,ADD->0 z1; a=FFFFFFFF,b=1,ADD->0 z1; a=1,b=2,SUB->FFFFFFFF z0
// 3. a=80000000,b=4: SLL->0 z1; SRL->08000000; SRA->F8000000; b=0 SRL->80000000
// 4. a=FFFFFFFF,b=1: SLT->1, SLTU->0; a=1,b=FFFFFFFF: SLT->0, SLTU->1; a=b=5: SLT->0 z1
// 5. alu_op=00001 and 11110 with a=2,b=1 -> result 0, zero 1
// 6. ADD a=2,b=1 in flight, rst=1 on same edge -> result 0, zero 1; after rst drops, next edge -> 3

Source files
------------

// File: rtl/alu_if.sv
// alu_if: operand, operation and result bundle between issue logic and the ALU
interface alu_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0] alu_op;
  logic [WIDTH-1:0] alu_result;
  logic zero;
  modport master (output a, b, alu_op, input alu_result, zero);
  modport slave (input a, b, alu_op, output alu_result, zero);
endinterface

// File: rtl/alu.sv
// alu: registered integer ALU; zero flag is decoded from the result register itself
module alu #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  alu_if.slave bus
);
  localparam int S = $clog2(WIDTH);
  logic [WIDTH-1:0] res;
  logic [S-1:0] sh;
  assign sh = bus.b[S-1:0];
  always_comb begin
    res = '0;
    case (bus.alu_op)
      5'b00000: res = bus.a + bus.b;
      5'b00010: res = bus.a - bus.b;
      5'b00100: res = bus.a << sh;
      5'b01000: res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      5'b01100: res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      5'b10000: res = bus.a ^ bus.b;
      5'b10100: res = bus.a >> sh;
      5'b10110: res = $signed(bus.a) >>> sh;
      5'b11000: res = bus.a | bus.b;
      5'b11100: res = bus.a & bus.b;
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk)
    bus.alu_result <= rst ? '0 : res;
  assign bus.zero = ~|bus.alu_result;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random checks of alu through a scoreboard queue
module tb_alu;
  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00010, SLL = 5'b00100, SLT = 5'b01000,
    SLTU = 5'b01100, XOR = 5'b10000, SRL = 5'b10100, SRA = 5'b10110, OR = 5'b11000, AND = 5'b11100;
  logic clk = 1'b0;
  logic rst;
  alu_if #(.WIDTH(32)) bus ();
  alu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int compared = 0;
  int mismatched = 0;
  logic [32:0] sb[$];
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] op, input logic [31:0] er);
    logic [32:0] e;
    bus.a = a;
    bus.b = b;
    bus.alu_op = op;
    sb.push_back({er, er == 32'd0});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, "/res"}, bus.alu_result, e[32:1]);
      cmp({tag, "/z"}, {31'd0, bus.zero}, {31'd0, e[0]});
    end
  endtask
  initial begin
    logic [31:0] ra, rb, re;
    logic [4:0] rop;
    rst = 1'b1;
    step("reset", 32'd2, 32'd1, ADD, 32'd0);
    rst = 1'b0;
    step("add", 32'd2, 32'd1, ADD, 32'd3);
    step("sub", 32'd2, 32'd1, SUB, 32'd1);
    step("and", 32'd2, 32'd1, AND, 32'd0);
    step("or", 32'd2, 32'd1, OR, 32'd3);
    step("xor", 32'd2, 32'd1, XOR, 32'd3);
    step("add0", 32'd0, 32'd0, ADD, 32'd0);
    step("addwrap", 32'hFFFFFFFF, 32'd1, ADD, 32'd0);
    step("subwrap", 32'd1, 32'd2, SUB, 32'hFFFFFFFF);
    step("sll", 32'h80000000, 32'd4, SLL, 32'd0);
    step("srl", 32'h80000000, 32'd4, SRL, 32'h08000000);
    step("sra", 32'h80000000, 32'd4, SRA, 32'hF8000000);
    step("srl0", 32'h80000000, 32'd0, SRL, 32'h80000000);
    step("sllhi", 32'h00000003, 32'hFFFFFFE1, SLL, 32'h00000006);
    step("slt_neg", 32'hFFFFFFFF, 32'd1, SLT, 32'd1);
    step("sltu_big", 32'hFFFFFFFF, 32'd1, SLTU, 32'd0);
    step("slt_pos", 32'd1, 32'hFFFFFFFF, SLT, 32'd0);
    step("sltu_small", 32'd1, 32'hFFFFFFFF, SLTU, 32'd1);
    step("slt_eq", 32'd5, 32'd5, SLT, 32'd0);
    step("bad01", 32'd2, 32'd1, 5'b00001, 32'd0);
    step("bad1e", 32'd2, 32'd1, 5'b11110, 32'd0);
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 4)
        0: begin rop = ADD; re = ra + rb; end
        1: begin rop = SUB; re = ra - rb; end
        2: begin rop = XOR; re = ra ^ rb; end
        default: begin rop = SRA; re = 32'($signed(ra) >>> rb[4:0]); end
      endcase
      step("rand", ra, rb, rop, re);
    end
    rst = 1'b1;
    step("rst_override", 32'd2, 32'd1, ADD, 32'd0);
    rst = 1'b0;
    step("after_rst", 32'd2, 32'd1, ADD, 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
